alu_seq_ctrl: RTL

- Multi-cycle control sequencer that drives the 16-bit ALU: accepts one instruction via valid/ready, holds a 4x16 register file, and presents operands then the function select to the ALU.
- Samples ALU result and carries, writes back to the register file, and keeps condition flags.
- Sits between instruction fetch/decode and the ALU datapath of the multi-cycle CPU.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_regfile.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encodings and flag bit positions for the ALU sequencer.
// Latency: none, this file holds only types and constants.
// Backpressure: none.
package alu_seq_pkg;

  // Opcodes match the ALU fn_sel codes one-to-one; LOADI never reaches the ALU.
  localparam logic [2:0] OP_MOV   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_NEG   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_NOT   = 3'd6;
  localparam logic [2:0] OP_LOADI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPND = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Bit positions inside the packed flag register.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Binary ops take x from R[rd] and y from R[rs]; unary ops take x from R[rs].
  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_OR);
  endfunction

  // Only the adder ops produce meaningful carry/overflow.
  function automatic logic updates_cv(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x16 register file with one synchronous write port and three combinational reads.
// Latency: a write lands on the clock edge; reads show the old value until that edge.
// Backpressure: none, the sequencer decides when writes happen.
module alu_seq_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [1:0]  raddr_a,
  output logic [15:0] rdata_a,
  input  logic [1:0]  raddr_b,
  output logic [15:0] rdata_b,
  input  logic [1:0]  raddr_dbg,
  output logic [15:0] rdata_dbg
);

  logic [15:0] regs [4];

  // Single write port; reset clears every register immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign rdata_dbg = regs[raddr_dbg];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer that stages operands, then a function select, into the 16-bit ALU and writes back.
// Latency: ALU ops write EXEC_CYCLES+1 edges after accept, done the cycle after; LOADI writes at accept.
// Backpressure: instr_ready is high only in IDLE; one instruction in flight, nothing is queued.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int         EXEC_CYCLES = 2,
  parameter logic [2:0] PARK_SEL    = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [2:0]  alu_fn_sel,
  input  logic [15:0] alu_z,
  input  logic        alu_carry,
  input  logic        alu_carry_n_1,
  output logic        done,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n,
  input  logic [1:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  rd_q;
  logic [2:0]  exec_cnt;
  logic [3:0]  flags;

  logic [2:0]  in_op;
  logic [1:0]  in_rd;
  logic [1:0]  in_rs;
  logic [10:0] in_imm;

  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_val;
  logic [15:0] rs_val;

  assign in_op  = instr[15:13];
  assign in_rd  = instr[12:11];
  assign in_rs  = instr[10:9];
  assign in_imm = instr[10:0];

  assign instr_ready = (state == ST_IDLE);

  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];
  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];

  // Operand reads use the incoming instruction fields; they only matter on the accept edge.
  alu_seq_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (wr_en),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .raddr_a   (in_rd),
    .rdata_a   (rd_val),
    .raddr_b   (in_rs),
    .rdata_b   (rs_val),
    .raddr_dbg (dbg_sel),
    .rdata_dbg (dbg_data)
  );

  // Write-back source: LOADI immediate on the accept edge, ALU result on the last EXEC edge.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd_q;
    wr_data = alu_z;
    if (state == ST_IDLE) begin
      wr_addr = in_rd;
      wr_data = {5'b0, in_imm};
      wr_en   = instr_valid && (in_op == OP_LOADI);
    end else if ((state == ST_EXEC) && (exec_cnt == 3'd0)) begin
      wr_en = 1'b1;
    end
  end

  // Main sequencer: operands settle a cycle before fn_sel moves, and fn_sel parks before
  // operands can change again, so the ALU only ever sees clean fn_sel transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_MOV;
      rd_q       <= 2'd0;
      exec_cnt   <= 3'd0;
      alu_x      <= 16'h0000;
      alu_y      <= 16'h0000;
      alu_fn_sel <= PARK_SEL;
      done       <= 1'b0;
      flags      <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q <= in_op;
            rd_q <= in_rd;
            if (in_op == OP_LOADI) begin
              flags[FLAG_Z] <= (wr_data == 16'h0000);
              flags[FLAG_N] <= wr_data[15];
              done          <= 1'b1;
              state         <= ST_WB;
            end else begin
              alu_x      <= is_binary(in_op) ? rd_val : rs_val;
              alu_y      <= is_binary(in_op) ? rs_val :
                            ((in_op == OP_INC) ? 16'h0001 : 16'h0000);
              alu_fn_sel <= PARK_SEL;
              state      <= ST_OPND;
            end
          end
        end
        ST_OPND: begin
          alu_fn_sel <= op_q;
          exec_cnt   <= 3'(EXEC_CYCLES - 1);
          state      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exec_cnt == 3'd0) begin
            flags[FLAG_Z] <= (wr_data == 16'h0000);
            flags[FLAG_N] <= wr_data[15];
            if (updates_cv(op_q)) begin
              flags[FLAG_C] <= alu_carry;
              flags[FLAG_V] <= alu_carry ^ alu_carry_n_1;
            end
            alu_fn_sel <= PARK_SEL;
            done       <= 1'b1;
            state      <= ST_WB;
          end else begin
            exec_cnt <= exec_cnt - 3'd1;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
